// File: rtl/axi_mmio_pkg.sv
// Shared AXI encodings, FSM state types and the default uart/bram/spi address map
// for the MMIO demultiplexer.
package axi_mmio_pkg;

  typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} resp_t;
  typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP} burst_t;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  localparam int DEF_N_SLV  = 3;
  localparam int DEF_ADDR_W = 31;

  // Slot 0 (uart) occupies the least significant ADDR_W bits.
  localparam logic [DEF_N_SLV*DEF_ADDR_W-1:0] DEF_SLV_BASE =
    {31'h6002_0000, 31'h6001_0000, 31'h6000_0000};
  localparam logic [DEF_N_SLV*DEF_ADDR_W-1:0] DEF_SLV_MASK =
    {31'h7FFF_0000, 31'h7FFF_0000, 31'h7FFF_E000};

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_mmio_decode.sv
// Address decoder: priority-resolved one-hot hit vector (lowest index wins),
// its encoded index, and a miss flag for the internal error responder.
module axi_mmio_decode
  import axi_mmio_pkg::*;
#(
  parameter int                        N_SLV    = DEF_N_SLV,
  parameter int                        ADDR_W   = DEF_ADDR_W,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = DEF_SLV_MASK,
  parameter int                        IDX_W    = idx_width(N_SLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_SLV-1:0]  hit,
  output logic [IDX_W-1:0]  idx,
  output logic              miss
);

  logic [N_SLV-1:0] raw_hit;

  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_hit
    assign raw_hit[gi] =
      (addr & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W];
  end

  // Keep only the lowest set bit so overlapping windows resolve deterministically.
  assign hit  = raw_hit & (~raw_hit + 1'b1);
  assign miss = ~|raw_hit;

  always_comb begin
    idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (raw_hit[i]) idx = i[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/axi_mmio_xbar.sv
// AXI4 1-to-N MMIO demux with independent read/write FSMs and a DECERR responder.
// Optional decode-error log enabled by defining AXI_MMIO_ERRLOG_EN.
module axi_mmio_xbar
  import axi_mmio_pkg::*;
#(
  parameter int                      N_SLV    = DEF_N_SLV,
  parameter int                      ADDR_W   = DEF_ADDR_W,
  parameter int                      DATA_W   = 32,
  parameter int                      ID_W     = 4,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [ID_W-1:0]            s_aw_id,
  input  logic [ADDR_W-1:0]          s_aw_addr,
  input  logic [7:0]                 s_aw_len,
  input  logic [2:0]                 s_aw_size,
  input  logic [1:0]                 s_aw_burst,
  input  logic                       s_aw_valid,
  output logic                       s_aw_ready,
  input  logic [DATA_W-1:0]          s_w_data,
  input  logic [DATA_W/8-1:0]        s_w_strb,
  input  logic                       s_w_last,
  input  logic                       s_w_valid,
  output logic                       s_w_ready,
  output logic [ID_W-1:0]            s_b_id,
  output logic [1:0]                 s_b_resp,
  output logic                       s_b_valid,
  input  logic                       s_b_ready,
  input  logic [ID_W-1:0]            s_ar_id,
  input  logic [ADDR_W-1:0]          s_ar_addr,
  input  logic [7:0]                 s_ar_len,
  input  logic [2:0]                 s_ar_size,
  input  logic [1:0]                 s_ar_burst,
  input  logic                       s_ar_valid,
  output logic                       s_ar_ready,
  output logic [ID_W-1:0]            s_r_id,
  output logic [DATA_W-1:0]          s_r_data,
  output logic [1:0]                 s_r_resp,
  output logic                       s_r_last,
  output logic                       s_r_valid,
  input  logic                       s_r_ready,
  output logic [N_SLV*ID_W-1:0]      m_aw_id,
  output logic [N_SLV*ADDR_W-1:0]    m_aw_addr,
  output logic [N_SLV*8-1:0]         m_aw_len,
  output logic [N_SLV*3-1:0]         m_aw_size,
  output logic [N_SLV*2-1:0]         m_aw_burst,
  output logic [N_SLV-1:0]           m_aw_valid,
  input  logic [N_SLV-1:0]           m_aw_ready,
  output logic [N_SLV*DATA_W-1:0]    m_w_data,
  output logic [N_SLV*DATA_W/8-1:0]  m_w_strb,
  output logic [N_SLV-1:0]           m_w_last,
  output logic [N_SLV-1:0]           m_w_valid,
  input  logic [N_SLV-1:0]           m_w_ready,
  input  logic [N_SLV*ID_W-1:0]      m_b_id,
  input  logic [N_SLV*2-1:0]         m_b_resp,
  input  logic [N_SLV-1:0]           m_b_valid,
  output logic [N_SLV-1:0]           m_b_ready,
  output logic [N_SLV*ID_W-1:0]      m_ar_id,
  output logic [N_SLV*ADDR_W-1:0]    m_ar_addr,
  output logic [N_SLV*8-1:0]         m_ar_len,
  output logic [N_SLV*3-1:0]         m_ar_size,
  output logic [N_SLV*2-1:0]         m_ar_burst,
  output logic [N_SLV-1:0]           m_ar_valid,
  input  logic [N_SLV-1:0]           m_ar_ready,
  input  logic [N_SLV*ID_W-1:0]      m_r_id,
  input  logic [N_SLV*DATA_W-1:0]    m_r_data,
  input  logic [N_SLV*2-1:0]         m_r_resp,
  input  logic [N_SLV-1:0]           m_r_last,
  input  logic [N_SLV-1:0]           m_r_valid,
  output logic [N_SLV-1:0]           m_r_ready,
  output logic [ADDR_W-1:0]          dec_err_addr,
  output logic                       dec_err_irq,
  input  logic                       dec_err_clr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idx_width(N_SLV);

  logic             run_reg;
  w_state_t         w_state_reg, w_state_next;
  r_state_t         r_state_reg, r_state_next;
  logic [ID_W-1:0]  aw_id_reg, ar_id_reg;
  logic [ADDR_W-1:0] aw_addr_reg, ar_addr_reg;
  logic [7:0]       aw_len_reg, ar_len_reg, beat_cnt_reg;
  logic [2:0]       aw_size_reg, ar_size_reg;
  logic [1:0]       aw_burst_reg, ar_burst_reg;
  logic [IDX_W-1:0] w_idx_reg, r_idx_reg, aw_idx, ar_idx;
  logic [N_SLV-1:0] w_oh_reg, r_oh_reg, aw_hit, ar_hit;
  logic             w_err_reg, r_err_reg, aw_miss, ar_miss;
  logic             aw_fire, ar_fire;

  axi_mmio_decode #(.N_SLV(N_SLV), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE),
                    .SLV_MASK(SLV_MASK), .IDX_W(IDX_W))
    u_aw_dec (.addr(s_aw_addr), .hit(aw_hit), .idx(aw_idx), .miss(aw_miss));

  axi_mmio_decode #(.N_SLV(N_SLV), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE),
                    .SLV_MASK(SLV_MASK), .IDX_W(IDX_W))
    u_ar_dec (.addr(s_ar_addr), .hit(ar_hit), .idx(ar_idx), .miss(ar_miss));

  // run_reg keeps the address readys low while reset is asserted.
  assign aw_fire = s_aw_valid && run_reg && (w_state_reg == W_IDLE);
  assign ar_fire = s_ar_valid && run_reg && (r_state_reg == R_IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      run_reg      <= 1'b0;
      w_state_reg  <= W_IDLE;
      r_state_reg  <= R_IDLE;
      beat_cnt_reg <= '0;
      aw_id_reg    <= '0; aw_addr_reg <= '0; aw_len_reg <= '0;
      aw_size_reg  <= '0; aw_burst_reg <= '0;
      w_idx_reg    <= '0; w_oh_reg <= '0; w_err_reg <= 1'b0;
      ar_id_reg    <= '0; ar_addr_reg <= '0; ar_len_reg <= '0;
      ar_size_reg  <= '0; ar_burst_reg <= '0;
      r_idx_reg    <= '0; r_oh_reg <= '0; r_err_reg <= 1'b0;
    end else begin
      run_reg     <= 1'b1;
      w_state_reg <= w_state_next;
      r_state_reg <= r_state_next;
      if (aw_fire) begin
        aw_id_reg   <= s_aw_id;   aw_addr_reg  <= s_aw_addr; aw_len_reg <= s_aw_len;
        aw_size_reg <= s_aw_size; aw_burst_reg <= s_aw_burst;
        w_idx_reg   <= aw_idx;    w_oh_reg     <= aw_hit;    w_err_reg  <= aw_miss;
      end
      if (ar_fire) begin
        ar_id_reg   <= s_ar_id;   ar_addr_reg  <= s_ar_addr; ar_len_reg <= s_ar_len;
        ar_size_reg <= s_ar_size; ar_burst_reg <= s_ar_burst;
        r_idx_reg   <= ar_idx;    r_oh_reg     <= ar_hit;    r_err_reg  <= ar_miss;
        beat_cnt_reg <= '0;
      end else if (r_state_reg == R_DATA && r_err_reg && s_r_ready) begin
        beat_cnt_reg <= beat_cnt_reg + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    s_aw_ready   = 1'b0;
    m_aw_valid   = '0;
    m_w_valid    = '0;
    s_w_ready    = 1'b0;
    m_b_ready    = '0;
    s_b_valid    = 1'b0;
    s_b_id       = aw_id_reg;
    s_b_resp     = RESP_OKAY;
    unique case (w_state_reg)
      W_IDLE: begin
        s_aw_ready = run_reg;
        if (aw_fire) w_state_next = aw_miss ? W_DATA : W_ADDR;
      end
      W_ADDR: begin
        m_aw_valid = w_oh_reg;
        if (m_aw_ready[w_idx_reg]) w_state_next = W_DATA;
      end
      W_DATA: begin
        if (w_err_reg) begin
          s_w_ready = 1'b1;
        end else begin
          m_w_valid = w_oh_reg & {N_SLV{s_w_valid}};
          s_w_ready = m_w_ready[w_idx_reg];
        end
        if (s_w_valid && s_w_ready && s_w_last) w_state_next = W_RESP;
      end
      W_RESP: begin
        if (w_err_reg) begin
          s_b_valid = 1'b1;
          s_b_resp  = RESP_DECERR;
        end else begin
          s_b_valid = m_b_valid[w_idx_reg];
          s_b_id    = m_b_id[w_idx_reg*ID_W +: ID_W];
          s_b_resp  = m_b_resp[w_idx_reg*2 +: 2];
          m_b_ready = w_oh_reg & {N_SLV{s_b_ready}};
        end
        if (s_b_valid && s_b_ready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next = r_state_reg;
    s_ar_ready   = 1'b0;
    m_ar_valid   = '0;
    m_r_ready    = '0;
    s_r_valid    = 1'b0;
    s_r_id       = ar_id_reg;
    s_r_data     = '0;
    s_r_resp     = RESP_OKAY;
    s_r_last     = 1'b0;
    unique case (r_state_reg)
      R_IDLE: begin
        s_ar_ready = run_reg;
        if (ar_fire) r_state_next = ar_miss ? R_DATA : R_ADDR;
      end
      R_ADDR: begin
        m_ar_valid = r_oh_reg;
        if (m_ar_ready[r_idx_reg]) r_state_next = R_DATA;
      end
      R_DATA: begin
        if (r_err_reg) begin
          s_r_valid = 1'b1;
          s_r_resp  = RESP_DECERR;
          s_r_last  = (beat_cnt_reg == ar_len_reg);
        end else begin
          s_r_valid = m_r_valid[r_idx_reg];
          s_r_id    = m_r_id[r_idx_reg*ID_W +: ID_W];
          s_r_data  = m_r_data[r_idx_reg*DATA_W +: DATA_W];
          s_r_resp  = m_r_resp[r_idx_reg*2 +: 2];
          s_r_last  = m_r_last[r_idx_reg];
          m_r_ready = r_oh_reg & {N_SLV{s_r_ready}};
        end
        if (s_r_valid && s_r_ready && s_r_last) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // Payloads fan out to every slave; only valid/ready are steered.
  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_fan
    assign m_aw_id[gi*ID_W +: ID_W]          = aw_id_reg;
    assign m_aw_addr[gi*ADDR_W +: ADDR_W]    = aw_addr_reg;
    assign m_aw_len[gi*8 +: 8]               = aw_len_reg;
    assign m_aw_size[gi*3 +: 3]              = aw_size_reg;
    assign m_aw_burst[gi*2 +: 2]             = aw_burst_reg;
    assign m_w_data[gi*DATA_W +: DATA_W]     = s_w_data;
    assign m_w_strb[gi*STRB_W +: STRB_W]     = s_w_strb;
    assign m_w_last[gi]                      = s_w_last;
    assign m_ar_id[gi*ID_W +: ID_W]          = ar_id_reg;
    assign m_ar_addr[gi*ADDR_W +: ADDR_W]    = ar_addr_reg;
    assign m_ar_len[gi*8 +: 8]               = ar_len_reg;
    assign m_ar_size[gi*3 +: 3]              = ar_size_reg;
    assign m_ar_burst[gi*2 +: 2]             = ar_burst_reg;
  end

`ifdef AXI_MMIO_ERRLOG_EN
  logic [ADDR_W-1:0] err_addr_reg;
  logic              err_irq_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_addr_reg <= '0;
      err_irq_reg  <= 1'b0;
    end else begin
      if (ar_fire && ar_miss)      err_addr_reg <= s_ar_addr;
      else if (aw_fire && aw_miss) err_addr_reg <= s_aw_addr;
      if ((ar_fire && ar_miss) || (aw_fire && aw_miss)) err_irq_reg <= 1'b1;
      else if (dec_err_clr)                             err_irq_reg <= 1'b0;
    end
  end

  assign dec_err_addr = err_addr_reg;
  assign dec_err_irq  = err_irq_reg;
`else
  logic unused_dec_err_clr;
  assign unused_dec_err_clr = dec_err_clr;
  assign dec_err_addr = '0;
  assign dec_err_irq  = 1'b0;
`endif

endmodule
